// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants and packer state encoding for the message block packer
package ascon_pkg;

  localparam int         BLK_SIZE_DEF  = 64;
  localparam int         BLK_BYTES_DEF = BLK_SIZE_DEF / 8;
  localparam logic [7:0] PAD_BYTE      = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_PAD  = 2'd2
  } pack_state_t;

endpackage

// File: rtl/msg_block_packer.sv
// rtl/msg_block_packer.sv - packs message bytes into padded cipher plaintext blocks
module msg_block_packer
  import ascon_pkg::*;
#(
  parameter int BLK_SIZE = BLK_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic                in_empty,
  output logic                in_ready,
  output logic [BLK_SIZE-1:0] out_block,
  output logic [3:0]          out_nbytes,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int                  BLK_BYTES = BLK_SIZE / 8;
  localparam logic [3:0]          LAST_IDX  = 4'(BLK_BYTES - 1);
  localparam logic [3:0]          FULL_CNT  = 4'(BLK_BYTES);
  localparam logic [BLK_SIZE-1:0] PAD_BLOCK = {PAD_BYTE, {(BLK_SIZE - 8){1'b0}}};

  pack_state_t         state, state_d;
  logic [3:0]          cnt, cnt_d, cnt_inc;
  logic [BLK_SIZE-1:0] blk_d;
  logic [3:0]          nbytes_d;
  logic                last_d;
  logic                pad_pending, pad_d;
  logic                accept, empty_go;

  // Byte k of a block sits in lane k counted from the MSB end.
  function automatic logic [BLK_SIZE-1:0] lane(input logic [7:0] b, input logic [3:0] k);
    return {{(BLK_SIZE - 8){1'b0}}, b} << (BLK_SIZE - 8 - 8 * int'(k));
  endfunction

  assign in_ready  = (state == ST_FILL) && !rst && !in_empty;
  assign accept    = in_valid && in_ready;
  assign empty_go  = (state == ST_FILL) && in_empty && (cnt == 4'd0);
  assign out_valid = (state != ST_FILL);
  assign busy      = (state != ST_FILL) || (cnt != 4'd0);
  assign cnt_inc   = cnt + 4'd1;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    blk_d    = out_block;
    nbytes_d = out_nbytes;
    last_d   = out_last;
    pad_d    = pad_pending;
    case (state)
      ST_FILL: begin
        if (empty_go) begin
          state_d  = ST_PAD;
          blk_d    = PAD_BLOCK;
          nbytes_d = 4'd0;
          last_d   = 1'b1;
        end else if (accept) begin
          // The buffer is zeroed on every return to FILL, so OR-ing lanes suffices.
          blk_d = out_block | lane(in_data, cnt);
          if (cnt == LAST_IDX) begin
            state_d  = ST_FULL;
            nbytes_d = FULL_CNT;
            last_d   = 1'b0;
            pad_d    = in_last;
          end else if (in_last) begin
            state_d  = ST_FULL;
            blk_d    = out_block | lane(in_data, cnt) | lane(PAD_BYTE, cnt_inc);
            nbytes_d = cnt_inc;
            last_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (pad_pending) begin
            state_d  = ST_PAD;
            blk_d    = PAD_BLOCK;
            nbytes_d = 4'd0;
            last_d   = 1'b1;
            pad_d    = 1'b0;
          end else begin
            state_d  = ST_FILL;
            cnt_d    = 4'd0;
            blk_d    = '0;
            nbytes_d = 4'd0;
            last_d   = 1'b0;
          end
        end
      end
      ST_PAD: begin
        if (out_ready) begin
          state_d  = ST_FILL;
          cnt_d    = 4'd0;
          blk_d    = '0;
          nbytes_d = 4'd0;
          last_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_FILL;
        cnt_d    = 4'd0;
        blk_d    = '0;
        nbytes_d = 4'd0;
        last_d   = 1'b0;
        pad_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      cnt         <= 4'd0;
      pad_pending <= 1'b0;
      out_block   <= '0;
      out_nbytes  <= 4'd0;
      out_last    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pad_pending <= pad_d;
      out_block   <= blk_d;
      out_nbytes  <= nbytes_d;
      out_last    <= last_d;
    end
  end

endmodule

// File: doc/msg_block_packer.md
MSG_BLOCK_PACKER -- requirements
Module: msg_block_packer

Interface
REQ-001 Parameter BLK_SIZE, default 64, block width in bits fed to the cipher plaintext port; BLK_BYTES = BLK_SIZE/8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  message byte.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_last  input  1  qualifies in_data as final message byte.
REQ-007 in_empty  input  1  one-cycle strobe: message of zero bytes.
REQ-008 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-009 out_block  output  BLK_SIZE  padded block to cipher plaintext input.
REQ-010 out_nbytes  output  4  count of message bytes in out_block, 0..BLK_BYTES.
REQ-011 out_last  output  1  final block of message.
REQ-012 out_valid  output  1  out_block/out_nbytes/out_last valid.
REQ-013 out_ready  input  1  cipher plaintext_ready; transfer when out_valid && out_ready.
REQ-014 busy  output  1  message in progress inside packer.

Function
REQ-015 States: FILL (collecting bytes), FULL (block presented), PAD (padding-only block presented).
REQ-016 in_ready = 1 only in FILL, not in reset, and not while in_empty is high.
REQ-017 Byte order: k-th accepted byte of a block (k=0..7) lands in out_block[BLK_SIZE-1-8k -: 8] (first byte in MSBs).
REQ-018 Byte counter cnt, 0..BLK_BYTES-1, increments per accepted byte, clears when FILL is entered.
REQ-019 Accept without in_last, cnt reaching BLK_BYTES: -> FULL, out_nbytes=8, out_last=0.
REQ-020 Accept with in_last, total n<8 bytes in block: byte n = 8'h80, bytes above n = 0, out_nbytes=n, out_last=1, -> FULL.
REQ-021 Accept with in_last, n=8: -> FULL, out_nbytes=8, out_last=0, pad_pending set.
REQ-022 FULL, transfer, pad_pending set: -> PAD with out_block = 8'h80 followed by zeros, out_nbytes=0, out_last=1; pad_pending cleared.
REQ-023 FULL or PAD, transfer, no pad_pending: -> FILL next cycle; out_valid deasserts.
REQ-024 in_empty honoured only in FILL with cnt=0: -> PAD-equivalent block (8'h80 then zeros, nbytes=0, last=1); ignored otherwise.
REQ-025 in_empty and in_valid high together with cnt=0: in_empty wins, byte not accepted (in_ready low).
REQ-026 out_valid high exactly in FULL and PAD; outputs held stable until transfer regardless of out_ready stalls.
REQ-027 Transfer latency: block presented the cycle after the completing byte is accepted; no back-to-back block overlap (single buffer).
REQ-028 busy = (state != FILL) || (cnt != 0).
REQ-029 in_last with in_valid low has no effect.

Reset
REQ-030 On rst: state FILL, cnt 0, pad_pending 0, out_block 0, out_nbytes 0, out_last 0, out_valid 0, busy 0, in_ready 0 during reset cycle.
REQ-031 rst mid-message or mid-transfer discards all buffered bytes; first cycle after rst behaves as fresh FILL.

Structure
REQ-032 Shared package ascon_pkg holds BLK_SIZE default, BLK_BYTES, PAD_BYTE = 8'h80, packer state encoding.
REQ-033 Single module; no sub-module; byte-lane insert and pad mask as internal combinational logic.

Verification
REQ-034 Bytes 01..05, last on 05, out_ready=1 -> out_block 0x0102030405800000, nbytes 5, last 1, in_ready low until transfer.
REQ-035 Bytes 00..07, last on 07 -> block 0x0001020304050607 nbytes 8 last 0, then 0x8000000000000000 nbytes 0 last 1.
REQ-036 in_empty pulse at idle -> single block 0x8000000000000000, nbytes 0, last 1; in_empty with cnt=3 ignored.
REQ-037 9 bytes 10..18, last on 18, out_ready low 5 cycles at first block -> first block stable 5 cycles, then 0x1112131415161718? No: 0x1011121314151617 nbytes 8 last 0, then 0x1880000000000000 nbytes 1 last 1.
REQ-038 rst asserted after 3 bytes -> all outputs reset values; subsequent bytes AA, last -> 0xAA80000000000000 nbytes 1.
REQ-039 Connected to cipher with all-zero 8-byte message -> cipher sees two plaintext blocks, busy falls after second transfer.
